sys_clken_gen: RTL and testbench
================================

Name: sys_clken_gen

Overview:
- Parametrised successor to the fixed three-output system PLL wrapper.
- Runs on the single PLL output clock and derives NUM_CH independent clock-enable streams, each at a programmable fractional rate mul/div.
- Qualifies the PLL lock indication and releases per-channel resets in a staggered sequence.
- Sits between the PLL and all downstream clock domains; new rates are reprogrammed at run time without rebuilding the PLL.

Parameters:
- NUM_CH, 3, number of enable/reset channels (1..8)
- ACC_W, 16, width of mul/div and of each phase accumulator
- LOCK_WAIT, 1024, consecutive cycles of synchronised lock required before release (>=1)
- STAGGER, 16, cycles between successive channel reset releases (>=1)
- RST_MUL, 1, reset-default mul for every channel
- RST_DIV, 1, reset-default div for every channel

Ports:
- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  raw PLL lock, asynchronous to clk
- cfg_we  in  1  config write strobe
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel to configure
- cfg_mul  in  ACC_W  numerator
- cfg_div  in  ACC_W  denominator
- ce  out  NUM_CH  per-channel clock-enable pulse
- ch_rst_n  out  NUM_CH  per-channel active-low reset, synchronous deassert
- ready  out  1  high when all channels are released
- lost_lock  out  1  one-cycle pulse on loss of lock while RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - ce=0, ch_rst_n=0, ready=0, lost_lock=0.
  - Accumulators=0; mul/div registers=RST_MUL/RST_DIV; sync flops=0; FSM=WAIT_LOCK.
- Lock sync: pll_locked passes through a 2-flop synchroniser (lk_s). All FSM decisions use lk_s only.
- FSM:
  - WAIT_LOCK: counter increments while lk_s=1 and clears to 0 when lk_s=0. When the count reaches LOCK_WAIT-1 with lk_s=1, go to RELEASE with idx=0 and stagger counter=0.
  - RELEASE: deassert ch_rst_n[0] on entry. Every STAGGER cycles deassert the next index. After ch_rst_n[NUM_CH-1] deasserts, go to RUN and set ready=1 on the same edge.
  - RUN: hold.
  - Any state, lk_s=0 while not in WAIT_LOCK: all ch_rst_n=0, ready=0, counters cleared, go to WAIT_LOCK. lost_lock=1 for one cycle only if the FSM was in RUN.
- Register timing: ch_rst_n and ready are registered. A raw lock drop reaches ch_rst_n=0 in 3 clk edges (2 sync + 1).
- Rate engine, per channel, evaluated every cycle while ch_rst_n[i]=1:
  - sum = acc + mul, computed at ACC_W+1 bits.
  - If div==0: ce=0, acc holds.
  - Else if sum >= div: ce=1, acc = sum - div.
  - Else: ce=0, acc = sum.
  - ce is registered: the decision made in cycle t is visible in cycle t+1.
  - mul>=div gives ce=1 every cycle. mul==0 gives ce never.
- While ch_rst_n[i]=0: acc[i]=0 and ce[i]=0. Config registers are kept.
- Config write: on cfg_we, mul/div[cfg_ch] load and acc[cfg_ch] clears on the same edge. ce[cfg_ch] is forced 0 for that cycle's update, and the new rate applies from the next cycle.
  - cfg_ch >= NUM_CH: write ignored.
  - A write during reset/RELEASE is accepted and takes effect at release.
- Long-run rate: exactly mul ce pulses per div cycles. No cumulative drift, because the accumulator is exact.

Decomposition:
- Shared package sys_clk_pkg:
  - FSM state enum {WAIT_LOCK, RELEASE, RUN}
  - default constants RST_MUL/RST_DIV
  - function for the cfg_ch width
- One natural sub-module, sys_clken_acc: a single-channel accumulator with mul/div registers, config load and ce output. Instantiate it NUM_CH times in a generate loop. The FSM, synchroniser and stagger logic stay in the top.

Test Plan:
- Lock qualification: LOCK_WAIT=8, STAGGER=4, NUM_CH=3; raise pll_locked at cycle 10 → ch_rst_n[0] rises at 10+2+8 (±1 per documented edge count), ch_rst_n[1] 4 cycles later, ch_rst_n[2] 4 cycles after that; ready rises together with ch_rst_n[2].
- Lock glitch: drop pll_locked for 1 cycle midway through WAIT_LOCK → counter restarts; release timing is measured from the re-rise; lost_lock stays 0.
- Fractional rate: ch1 mul=3 div=8, run 800 cycles after release → exactly 300 ce[1] pulses; max gap 3 cycles, min gap 2.
- Edge rates: ch0 mul=5 div=5 → ce[0] high every cycle; ch2 div=0 → ce[2] never; ch1 mul=0 → ce[1] never.
- Live reconfig: in RUN, write ch0 mul=1 div=4 → the update cycle has ce[0]=0, then pulses follow every 4th cycle; other channels are unaffected, cycle for cycle.
- Loss of lock in RUN: drop pll_locked → single-cycle lost_lock pulse; all ch_rst_n=0 and ce=0 within 3 edges; ready=0. Re-lock → full staggered sequence repeats with the programmed rates retained. Asserting rst_n low mid-RELEASE → all outputs 0 immediately and config back to defaults.

Source files
------------

// File: rtl/sys_clk_pkg.sv
// Shared types and constants for the clock-enable generator: FSM states,
// reset-default rates and the channel-select width helper.
package sys_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } fsm_state_e;

  localparam int unsigned DEF_RST_MUL = 32'd1;
  localparam int unsigned DEF_RST_DIV = 32'd1;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/sys_clken_acc.sv
// Single-channel fractional rate engine: emits mul enable pulses per div cycles
// using an exact phase accumulator, with a run-time loadable mul/div pair.
module sys_clken_acc
  import sys_clk_pkg::*;
#(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned RST_MUL = DEF_RST_MUL,
  parameter int unsigned RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_mul,
  input  logic [ACC_W-1:0] cfg_div,
  output logic             ce
);

  logic [ACC_W-1:0] mul_r;
  logic [ACC_W-1:0] div_r;
  logic [ACC_W-1:0] acc_r;
  logic             ce_r;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W:0]   div_ext_s;

  // One extra bit so acc + mul never wraps before the compare.
  assign sum_s     = {1'b0, acc_r} + {1'b0, mul_r};
  assign div_ext_s = {1'b0, div_r};

  // Config load takes priority; otherwise advance the accumulator while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_r <= ACC_W'(RST_MUL);
      div_r <= ACC_W'(RST_DIV);
      acc_r <= '0;
      ce_r  <= 1'b0;
    end else if (cfg_we) begin
      mul_r <= cfg_mul;
      div_r <= cfg_div;
      acc_r <= '0;
      ce_r  <= 1'b0;
    end else if (!en) begin
      acc_r <= '0;
      ce_r  <= 1'b0;
    end else if (div_r == '0) begin
      ce_r  <= 1'b0;
    end else if (sum_s >= div_ext_s) begin
      ce_r  <= 1'b1;
      acc_r <= ACC_W'(sum_s - div_ext_s);
    end else begin
      ce_r  <= 1'b0;
      acc_r <= sum_s[ACC_W-1:0];
    end
  end

  assign ce = ce_r;

endmodule

// File: rtl/sys_clken_gen.sv
// PLL-side clock-enable generator: qualifies lock, releases channel resets in a
// staggered sequence and drives one fractional-rate enable per channel.
module sys_clken_gen
  import sys_clk_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned STAGGER   = 16,
  parameter int unsigned RST_MUL   = DEF_RST_MUL,
  parameter int unsigned RST_DIV   = DEF_RST_DIV
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pll_locked,
  input  logic                            cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]                cfg_mul,
  input  logic [ACC_W-1:0]                cfg_div,
  output logic [NUM_CH-1:0]               ce,
  output logic [NUM_CH-1:0]               ch_rst_n,
  output logic                            ready,
  output logic                            lost_lock
);

  localparam int unsigned CHW = ch_idx_w(NUM_CH);
  localparam int unsigned LCW = (LOCK_WAIT > 32'd1) ? $clog2(LOCK_WAIT) : 32'd1;
  localparam int unsigned SCW = (STAGGER > 32'd1) ? $clog2(STAGGER) : 32'd1;

  logic              lk_meta_r;
  logic              lk_s_r;
  fsm_state_e        state_r;
  logic [LCW-1:0]    lock_cnt_r;
  logic [SCW-1:0]    stag_cnt_r;
  logic [CHW-1:0]    idx_r;
  logic [CHW-1:0]    idx_nxt_s;
  logic [NUM_CH-1:0] ch_rst_n_r;
  logic              ready_r;
  logic              lost_lock_r;
  logic              drop_s;
  logic [NUM_CH-1:0] en_s;

  // Two-flop synchroniser for the raw PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_r <= 1'b0;
      lk_s_r    <= 1'b0;
    end else begin
      lk_meta_r <= pll_locked;
      lk_s_r    <= lk_meta_r;
    end
  end

  assign drop_s    = ~lk_s_r & (state_r != WAIT_LOCK);
  assign idx_nxt_s = idx_r + CHW'(1);
  // Gating with drop_s clears ce on the same edge that reasserts the channel reset.
  assign en_s      = ch_rst_n_r & {NUM_CH{~drop_s}};

  // Lock qualification, staggered release and loss-of-lock handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= WAIT_LOCK;
      lock_cnt_r  <= '0;
      stag_cnt_r  <= '0;
      idx_r       <= '0;
      ch_rst_n_r  <= '0;
      ready_r     <= 1'b0;
      lost_lock_r <= 1'b0;
    end else begin
      lost_lock_r <= 1'b0;
      if (drop_s) begin
        state_r     <= WAIT_LOCK;
        lock_cnt_r  <= '0;
        stag_cnt_r  <= '0;
        idx_r       <= '0;
        ch_rst_n_r  <= '0;
        ready_r     <= 1'b0;
        lost_lock_r <= (state_r == RUN);
      end else begin
        case (state_r)
          WAIT_LOCK: begin
            if (!lk_s_r) begin
              lock_cnt_r <= '0;
            end else if (lock_cnt_r == LCW'(LOCK_WAIT - 32'd1)) begin
              lock_cnt_r <= '0;
              stag_cnt_r <= '0;
              idx_r      <= '0;
              ch_rst_n_r <= NUM_CH'(1);
              if (NUM_CH == 32'd1) begin
                state_r <= RUN;
                ready_r <= 1'b1;
              end else begin
                state_r <= RELEASE;
              end
            end else begin
              lock_cnt_r <= lock_cnt_r + LCW'(1);
            end
          end
          RELEASE: begin
            if (stag_cnt_r == SCW'(STAGGER - 32'd1)) begin
              stag_cnt_r <= '0;
              idx_r      <= idx_nxt_s;
              ch_rst_n_r <= ch_rst_n_r | (NUM_CH'(1) << idx_nxt_s);
              if (idx_nxt_s == CHW'(NUM_CH - 32'd1)) begin
                state_r <= RUN;
                ready_r <= 1'b1;
              end else begin
                state_r <= RELEASE;
              end
            end else begin
              stag_cnt_r <= stag_cnt_r + SCW'(1);
            end
          end
          RUN: begin
            state_r <= RUN;
          end
          default: begin
            state_r    <= WAIT_LOCK;
            lock_cnt_r <= '0;
            stag_cnt_r <= '0;
            idx_r      <= '0;
            ch_rst_n_r <= '0;
            ready_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Out-of-range channel selects match no instance, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sys_clken_acc #(
      .ACC_W  (ACC_W),
      .RST_MUL(RST_MUL),
      .RST_DIV(RST_DIV)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_s[i]),
      .cfg_we (cfg_we && (cfg_ch == CHW'(i))),
      .cfg_mul(cfg_mul),
      .cfg_div(cfg_div),
      .ce     (ce[i])
    );
  end

  assign ch_rst_n  = ch_rst_n_r;
  assign ready     = ready_r;
  assign lost_lock = lost_lock_r;

endmodule

// File: tb/tb_sys_clken_gen.sv
// Directed bench for sys_clken_gen: lock qualification, staggered release,
// fractional and edge rates, live reconfiguration, lock loss and async reset.
module tb_sys_clken_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_mul;
  logic [15:0] cfg_div;
  logic [2:0]  ce;
  logic [2:0]  ch_rst_n;
  logic        ready;
  logic        lost_lock;

  int checks   = 0;
  int failures = 0;
  int lost_cnt = 0;
  int cyc      = 0;
  int n0, n1, n2, last, gap, gmin, gmax, w, w2, t;
  logic [2:0] exp_v;

  sys_clken_gen #(
    .NUM_CH(3), .ACC_W(16), .LOCK_WAIT(8), .STAGGER(4), .RST_MUL(1), .RST_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mul(cfg_mul), .cfg_div(cfg_div), .ce(ce),
    .ch_rst_n(ch_rst_n), .ready(ready), .lost_lock(lost_lock)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (lost_lock === 1'b1) lost_cnt <= lost_cnt + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] m, input logic [15:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_mul = m;
    cfg_div = d;
    tick(1);
    cfg_we  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; cfg_we = 1'b0;
    cfg_ch = 2'd0; cfg_mul = 16'd0; cfg_div = 16'd0;
    tick(3);
    chk("rst_ce", ce, 3'b000);
    chk("rst_ch_rst_n", ch_rst_n, 3'b000);
    chk("rst_ready", ready, 1'b0);
    chk("rst_lost_lock", lost_lock, 1'b0);

    // Rates programmed while still held in reset-release wait.
    rst_n = 1'b1;
    tick(2);
    cfg_write(2'd0, 16'd5, 16'd5);
    cfg_write(2'd1, 16'd3, 16'd8);
    cfg_write(2'd2, 16'd7, 16'd0);
    cfg_write(2'd3, 16'd0, 16'd0);
    tick(2);
    chk("wait_ch_rst_n", ch_rst_n, 3'b000);

    // One-cycle lock glitch; release timing counts from the re-rise.
    pll_locked = 1'b1; tick(4);
    pll_locked = 1'b0; tick(1);
    pll_locked = 1'b1;
    tick(9);  chk("glitch_hold", ch_rst_n, 3'b000);
    tick(1);  chk("rel0", ch_rst_n, 3'b001); chk("rel0_ready", ready, 1'b0);
    tick(3);  chk("rel0_hold", ch_rst_n, 3'b001);
    tick(1);  chk("rel1", ch_rst_n, 3'b011);
    tick(3);  chk("rel1_hold", ch_rst_n, 3'b011); chk("rel1_ready", ready, 1'b0);
    tick(1);  chk("rel2", ch_rst_n, 3'b111); chk("ready_up", ready, 1'b1);
    chk("glitch_no_lost", lost_cnt, 0);

    // 800-cycle window: 3/8 on ch1, full rate on ch0, div=0 on ch2.
    n0 = 0; n1 = 0; n2 = 0; last = -1; gmin = 1000; gmax = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (ce[0]) n0++;
      if (ce[2]) n2++;
      if (ce[1]) begin
        n1++;
        if (last >= 0) begin
          gap = i - last;
          if (gap > gmax) gmax = gap;
          if (gap < gmin) gmin = gap;
        end
        last = i;
      end
    end
    chk("frac_count", n1, 300);
    chk("frac_gap_max", gmax, 3);
    chk("frac_gap_min", gmin, 2);
    chk("full_rate_count", n0, 800);
    chk("div0_count", n2, 0);

    // Live reconfiguration of ch0 with ch1 silenced and ch2 at half rate.
    cfg_write(2'd1, 16'd0, 16'd8);
    cfg_write(2'd2, 16'd1, 16'd2);
    w2 = cyc;
    tick(5);
    chk("ce0_before_reconfig", ce[0], 1'b1);
    cfg_write(2'd0, 16'd1, 16'd4);
    w = cyc;
    for (int d = 0; d <= 8; d++) begin
      t = w + d;
      exp_v[0] = (d > 0) && ((d % 4) == 0);
      exp_v[1] = 1'b0;
      exp_v[2] = ((t - w2) > 0) && (((t - w2) % 2) == 0);
      chk("reconfig_ce", ce, exp_v);
      if (d < 8) tick(1);
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ce[0]) n0++;
      if (ce[1]) n1++;
    end
    chk("quarter_rate_count", n0, 10);
    chk("mul0_count", n1, 0);

    // Loss of lock while running.
    pll_locked = 1'b0;
    tick(1); chk("drop_e1", ch_rst_n, 3'b111);
    tick(1); chk("drop_e2", ch_rst_n, 3'b111); chk("drop_e2_lost", lost_lock, 1'b0);
    tick(1); chk("drop_e3_ch_rst_n", ch_rst_n, 3'b000); chk("drop_e3_ce", ce, 3'b000);
    chk("drop_e3_ready", ready, 1'b0); chk("drop_e3_lost", lost_lock, 1'b1);
    tick(1); chk("drop_e4_lost", lost_lock, 1'b0); chk("lost_pulse_count", lost_cnt, 1);

    // Re-lock keeps the programmed rates.
    tick(3);
    pll_locked = 1'b1;
    tick(10); chk("relock_rel0", ch_rst_n, 3'b001);
    tick(3);  chk("relock_ce0_pre", ce[0], 1'b0);
    tick(1);  chk("relock_ce0_first", ce[0], 1'b1); chk("relock_rel1", ch_rst_n, 3'b011);
    tick(4);  chk("relock_rel2", ch_rst_n, 3'b111); chk("relock_ready", ready, 1'b1);
    tick(1);  chk("relock_ce2_pre", ce[2], 1'b0);
    tick(1);  chk("relock_ce2_first", ce[2], 1'b1);

    // Async reset in the middle of the release sequence.
    pll_locked = 1'b0; tick(6);
    pll_locked = 1'b1; tick(12);
    chk("mid_release", ch_rst_n, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("arst_ce", ce, 3'b000);
    chk("arst_ch_rst_n", ch_rst_n, 3'b000);
    chk("arst_ready", ready, 1'b0);
    chk("arst_lost_lock", lost_lock, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(10); chk("post_rst_rel0", ch_rst_n, 3'b001);
    tick(9);  chk("default_rates", ce, 3'b111); chk("post_rst_ready", ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
